// File: rtl/vram_wr_arbiter.sv
// Framebuffer RAM write-port arbiter: CPU single-word writes share the port with a linear fill engine.
// Optional macro VRAM_WR_STATS_EN adds saturating write counters (cpu_wr_cnt, fill_wr_cnt) and stats_clr.
module vram_wr_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  w_clk,
  input  logic                  rst_n,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_d,
  output logic                  cpu_ready,
  input  logic                  fill_go,
  input  logic [ADDR_WIDTH-1:0] fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_len,
  input  logic [DATA_WIDTH-1:0] fill_val,
  input  logic                  fill_abort,
  output logic                  fill_busy,
  output logic                  fill_done,
`ifdef VRAM_WR_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           cpu_wr_cnt,
  output logic [15:0]           fill_wr_cnt,
`endif
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_adr,
  output logic [DATA_WIDTH-1:0] d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]            STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE    = 1;

  state_t                  state, state_d;
  logic [3:0]              streak;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [ADDR_WIDTH-1:0]   remaining;
  logic [DATA_WIDTH-1:0]   fill_val_q;

  logic in_fill;
  logic force_fill;
  logic cpu_grant;
  logic fill_grant;
  logic fill_load;

  // Arbitration is purely combinational so cpu_ready reflects the current streak.
  always_comb begin
    in_fill    = (state == FILL);
    force_fill = in_fill && (streak == STREAK_MAX);
    cpu_ready  = ~force_fill;
    cpu_grant  = cpu_valid && cpu_ready;
    fill_grant = in_fill && !fill_abort && !cpu_grant;
    fill_load  = (state == IDLE) && fill_go && !fill_abort;
    fill_busy  = in_fill;
    fill_done  = (state == DONE);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (fill_load) state_d = (fill_len == '0) ? DONE : FILL;
      end
      FILL: begin
        if (fill_abort)                              state_d = IDLE;
        else if (fill_grant && remaining == ADR_ONE) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_adr    <= '0;
      remaining  <= '0;
      fill_val_q <= '0;
    end else if (fill_load) begin
      cur_adr    <= fill_start;
      remaining  <= fill_len;
      fill_val_q <= fill_val;
    end else if (fill_grant) begin
      cur_adr    <= cur_adr + ADR_ONE;
      remaining  <= remaining - ADR_ONE;
    end
  end

  // Streak counts CPU wins while a fill waits; any fill win or leaving FILL resets it.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!in_fill || fill_grant) begin
      streak <= '0;
    end else if (cpu_grant && streak != STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= 1'b0;
      w_adr <= '0;
      d     <= '0;
    end else if (cpu_grant) begin
      we    <= 1'b1;
      w_adr <= cpu_adr;
      d     <= cpu_d;
    end else if (fill_grant) begin
      we    <= 1'b1;
      w_adr <= cur_adr;
      d     <= fill_val_q;
    end else begin
      we    <= 1'b0;
    end
  end

`ifdef VRAM_WR_STATS_EN
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wr_cnt  <= '0;
      fill_wr_cnt <= '0;
    end else if (stats_clr) begin
      cpu_wr_cnt  <= '0;
      fill_wr_cnt <= '0;
    end else begin
      if (cpu_grant && cpu_wr_cnt != '1)   cpu_wr_cnt  <= cpu_wr_cnt + 16'd1;
      if (fill_grant && fill_wr_cnt != '1) fill_wr_cnt <= fill_wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed self-checking bench for vram_wr_arbiter (STARVE_LIMIT=4); stats checks when VRAM_WR_STATS_EN is defined.
module tb_vram_wr_arbiter;

  logic        w_clk;
  logic        rst_n;
  logic        cpu_valid;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_d;
  logic        cpu_ready;
  logic        fill_go;
  logic [15:0] fill_start;
  logic [15:0] fill_len;
  logic [7:0]  fill_val;
  logic        fill_abort;
  logic        fill_busy;
  logic        fill_done;
  logic        we;
  logic [15:0] w_adr;
  logic [7:0]  d;
`ifdef VRAM_WR_STATS_EN
  logic        stats_clr;
  logic [15:0] cpu_wr_cnt;
  logic [15:0] fill_wr_cnt;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  vram_wr_arbiter #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (16),
    .STARVE_LIMIT(4)
  ) dut (
    .w_clk      (w_clk),
    .rst_n      (rst_n),
    .cpu_valid  (cpu_valid),
    .cpu_adr    (cpu_adr),
    .cpu_d      (cpu_d),
    .cpu_ready  (cpu_ready),
    .fill_go    (fill_go),
    .fill_start (fill_start),
    .fill_len   (fill_len),
    .fill_val   (fill_val),
    .fill_abort (fill_abort),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
`ifdef VRAM_WR_STATS_EN
    .stats_clr  (stats_clr),
    .cpu_wr_cnt (cpu_wr_cnt),
    .fill_wr_cnt(fill_wr_cnt),
`endif
    .we         (we),
    .w_adr      (w_adr),
    .d          (d)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [15:0] adr, input logic [7:0] val);
    chk({tag, "_we"}, 32'(we), 32'd1);
    chk({tag, "_adr"}, 32'(w_adr), 32'(adr));
    chk({tag, "_d"}, 32'(d), 32'(val));
  endtask

  task automatic start_fill(input logic [15:0] s, input logic [15:0] n, input logic [7:0] v);
    fill_go    = 1'b1;
    fill_start = s;
    fill_len   = n;
    fill_val   = v;
    tick();
    fill_go    = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    int unsigned cpu_n;

    rst_n      = 1'b0;
    cpu_valid  = 1'b0;
    cpu_adr    = '0;
    cpu_d      = '0;
    fill_go    = 1'b0;
    fill_start = '0;
    fill_len   = '0;
    fill_val   = '0;
    fill_abort = 1'b0;
`ifdef VRAM_WR_STATS_EN
    stats_clr  = 1'b0;
`endif
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", 32'(w_adr), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Wrapping fill: FFFE, FFFF, 0000, 0001 with value A5.
    start_fill(16'hFFFE, 16'd4, 8'hA5);
    chk("wrap_busy0", 32'(fill_busy), 32'd1);
    chk("wrap_we0", 32'(we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      a = 16'hFFFE + 16'(i);
      chk_write("wrap", a, 8'hA5);
      chk("wrap_done", 32'(fill_done), (i == 3) ? 32'd1 : 32'd0);
      chk("wrap_busy", 32'(fill_busy), (i == 3) ? 32'd0 : 32'd1);
    end
    tick();
    chk("wrap_we_end", 32'(we), 32'd0);
    chk("wrap_done_end", 32'(fill_done), 32'd0);

    // Zero-length fill.
    start_fill(16'h0100, 16'd0, 8'h99);
    chk("len0_done", 32'(fill_done), 32'd1);
    chk("len0_we", 32'(we), 32'd0);
    chk("len0_busy", 32'(fill_busy), 32'd0);
    tick();
    chk("len0_done2", 32'(fill_done), 32'd0);
    chk("len0_we2", 32'(we), 32'd0);

    // Starvation guard: every 5th edge is a forced fill write.
    start_fill(16'h0200, 16'd10, 8'h3C);
    cpu_valid = 1'b1;
    cpu_n = 0;
    for (int e = 1; e <= 50; e++) begin
      cpu_adr = 16'h1000 + 16'(cpu_n);
      cpu_d   = 8'(cpu_n);
      chk("starve_ready", 32'(cpu_ready), (e % 5 == 0) ? 32'd0 : 32'd1);
      tick();
      if (e % 5 == 0) begin
        a = 16'h0200 + 16'(e / 5 - 1);
        chk_write("starve_fill", a, 8'h3C);
      end else begin
        a = 16'h1000 + 16'(cpu_n);
        chk_write("starve_cpu", a, 8'(cpu_n));
        cpu_n++;
      end
      chk("starve_busy", 32'(fill_busy), (e == 50) ? 32'd0 : 32'd1);
    end
    cpu_valid = 1'b0;
    chk("starve_done", 32'(fill_done), 32'd1);
    chk("starve_cpu_total", 32'(cpu_n), 32'd40);
    tick();
    chk("starve_we_end", 32'(we), 32'd0);

    // Abort after three fill writes, then a fresh fill is accepted.
    start_fill(16'h0300, 16'd8, 8'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      a = 16'h0300 + 16'(i);
      chk_write("abort_fill", a, 8'h77);
    end
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_busy", 32'(fill_busy), 32'd0);
    chk("abort_done", 32'(fill_done), 32'd0);
    tick();
    chk("abort_we2", 32'(we), 32'd0);
    chk("abort_done2", 32'(fill_done), 32'd0);
    start_fill(16'h0400, 16'd1, 8'h11);
    chk("refill_busy", 32'(fill_busy), 32'd1);
    tick();
    chk_write("refill", 16'h0400, 8'h11);
    chk("refill_done", 32'(fill_done), 32'd1);
    tick();
    chk("refill_we_end", 32'(we), 32'd0);

    // fill_go while busy is ignored.
    start_fill(16'h0500, 16'd3, 8'h22);
    fill_go    = 1'b1;
    fill_start = 16'h0900;
    fill_len   = 16'd5;
    fill_val   = 8'hEE;
    tick();
    fill_go = 1'b0;
    chk_write("busygo0", 16'h0500, 8'h22);
    tick();
    chk_write("busygo1", 16'h0501, 8'h22);
    tick();
    chk_write("busygo2", 16'h0502, 8'h22);
    chk("busygo_done", 32'(fill_done), 32'd1);
    tick();
    chk("busygo_we_end", 32'(we), 32'd0);
    chk("busygo_busy_end", 32'(fill_busy), 32'd0);

`ifdef VRAM_WR_STATS_EN
    chk("stats_cpu", 32'(cpu_wr_cnt), 32'd40);
    chk("stats_fill", 32'(fill_wr_cnt), 32'd21);
    stats_clr = 1'b1;
    cpu_valid = 1'b1;
    cpu_adr   = 16'h0042;
    cpu_d     = 8'h42;
    tick();
    stats_clr = 1'b0;
    cpu_valid = 1'b0;
    chk_write("stats_clr_wr", 16'h0042, 8'h42);
    chk("stats_clr_cpu", 32'(cpu_wr_cnt), 32'd0);
    chk("stats_clr_fill", 32'(fill_wr_cnt), 32'd0);
    tick();
    chk("stats_idle_cpu", 32'(cpu_wr_cnt), 32'd0);
`endif

    // Reset in the middle of a long fill.
    start_fill(16'h0600, 16'd100, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      tick();
      a = 16'h0600 + 16'(i);
      chk_write("midrst_fill", a, 8'h5A);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_adr", 32'(w_adr), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    chk("midrst_busy", 32'(fill_busy), 32'd0);
    chk("midrst_done", 32'(fill_done), 32'd0);
    chk("midrst_ready", 32'(cpu_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_we", 32'(we), 32'd0);
      chk("postrst_busy", 32'(fill_busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_wr_arbiter.md
Name: vram_wr_arbiter

Overview:
- Owns the framebuffer RAM write port (we, w_adr, d); the display read port is untouched.
- Shares that port between two requesters: a CPU single-word write channel (valid/ready) and a hardware fill engine that writes a constant value over a linear address range (clear screen, solid blocks).
- CPU has priority; a starvation guard guarantees fill progress.

Parameters:
- DATA_WIDTH, 8, pixel word width (matches the framebuffer RAM).
- ADDR_WIDTH, 16, framebuffer address width (covers 53760 pixels).
- STARVE_LIMIT, 4, max consecutive CPU writes while a fill is pending before one fill write is forced; legal range 1..15.

Ports:
- w_clk  in  1  write-side clock, same clock as the RAM write port.
- rst_n  in  1  asynchronous active-low reset.
- cpu_valid  in  1  CPU write request.
- cpu_adr  in  ADDR_WIDTH  CPU write address.
- cpu_d  in  DATA_WIDTH  CPU write data.
- cpu_ready  out  1  combinational grant; a transfer occurs on an edge where cpu_valid & cpu_ready.
- fill_go  in  1  start-fill pulse.
- fill_start  in  ADDR_WIDTH  first fill address, sampled with fill_go.
- fill_len  in  ADDR_WIDTH  number of words to fill, sampled with fill_go.
- fill_val  in  DATA_WIDTH  fill value, sampled with fill_go.
- fill_abort  in  1  cancel an active fill.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse when a fill completes normally.
- we  out  1  RAM write enable (registered).
- w_adr  out  ADDR_WIDTH  RAM write address (registered).
- d  out  DATA_WIDTH  RAM write data (registered).

Behaviour:
- Reset (async, rst_n=0): we=0, w_adr=0, d=0, fill_busy=0, fill_done=0, state=IDLE, streak=0, fill registers=0. cpu_ready is combinational and follows the cpu_ready equation with fill_busy=0.
- Clock and reset: single clock domain, w_clk.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: on fill_go & ~fill_abort, latch start/len/val.
    - len=0: go to DONE (no writes).
    - Otherwise: go to FILL with fill_busy=1.
  - fill_go while not in IDLE is ignored.
  - FILL: on each fill grant edge, write cur_adr and fill_val, cur_adr+1 (wraps modulo 2^ADDR_WIDTH), remaining-1. The edge that issues the last word (remaining=1) moves to DONE.
  - DONE: fill_done=1 for exactly one cycle, fill_busy=0, return to IDLE.
  - fill_abort in FILL: go to IDLE next edge. No fill write is issued on that edge, no fill_done, fill_busy=0. Writes already issued stand.
  - fill_abort in IDLE or DONE: no effect. DONE still pulses fill_done.
- Arbitration, evaluated each cycle:
  - force_fill = (state==FILL) & (streak==STARVE_LIMIT).
  - cpu_ready = ~force_fill.
  - CPU grant = cpu_valid & cpu_ready.
  - Fill grant = (state==FILL) & ~fill_abort & ~(CPU grant).
- streak rules:
  - +1 on each CPU grant while state==FILL, saturating at STARVE_LIMIT.
  - Cleared on a fill grant or whenever state!=FILL.
- Write port: on a grant edge, we=1 next cycle with the winner's address and data; else we=0. w_adr and d hold their last values when we=0.
- Latency: request grant edge to RAM write edge = 1 cycle.
- Throughput: one write per cycle total. A lone fill of N words completes in N cycles plus the DONE cycle.
- Simultaneous CPU and fill writes to the same address: only one write per cycle is possible; the last write wins, in grant order.
- CPU traffic is never blocked when no fill is active.

Optional Feature:
- Macro VRAM_WR_STATS_EN.
- Defined: adds outputs cpu_wr_cnt[15:0] and fill_wr_cnt[15:0], counting granted writes of each type. Both saturate at 16'hFFFF, reset to 0 on rst_n, and clear synchronously on a new input stats_clr (stats_clr takes precedence over an increment in the same cycle).
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-fill (fill_len=100, assert rst_n=0 after 10 writes) -> all outputs 0 immediately, fill_busy=0, no further we.
- Fill start=16'hFFFE, len=4, val=8'hA5, no CPU -> we on 4 consecutive cycles, addresses FFFE, FFFF, 0000, 0001, all data A5; fill_done one cycle after the last write; fill_busy low that cycle.
- fill_len=0 -> no we; fill_done pulses the cycle after fill_go.
- Fill len=10 with cpu_valid held high and STARVE_LIMIT=4 -> pattern of 4 CPU writes then 1 fill write, with cpu_ready=0 on each forced cycle; all 10 fill words are written; no CPU write is lost.
- fill_abort asserted after 3 fill writes -> exactly 3 fill writes, no fill_done, fill_busy=0 next cycle; a later fill_go is accepted.
- fill_go while busy -> ignored; the original range completes unchanged. With VRAM_WR_STATS_EN defined, counters match the number of granted writes; stats_clr zeroes them.
